// File: rtl/alu_md_pkg.sv
// ------------------------------------------------------------------
// alu_md_pkg : shared op encodings and default engine cycle counts
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_md_pkg;

  localparam logic [3:0] C_ALU_AND  = 4'd0;
  localparam logic [3:0] C_ALU_OR   = 4'd1;
  localparam logic [3:0] C_ALU_ADD  = 4'd2;
  localparam logic [3:0] C_ALU_SUB  = 4'd3;
  localparam logic [3:0] C_ALU_XOR  = 4'd4;
  localparam logic [3:0] C_ALU_NOR  = 4'd5;
  localparam logic [3:0] C_ALU_SLT  = 4'd6;
  localparam logic [3:0] C_ALU_SLTU = 4'd7;
  localparam logic [3:0] C_ALU_SLL  = 4'd8;
  localparam logic [3:0] C_ALU_SRL  = 4'd9;
  localparam logic [3:0] C_ALU_SRA  = 4'd10;
  localparam logic [3:0] C_ALU_LUI  = 4'd11;

  localparam logic [2:0] C_MD_MULT  = 3'd0;
  localparam logic [2:0] C_MD_MULTU = 3'd1;
  localparam logic [2:0] C_MD_DIV   = 3'd2;
  localparam logic [2:0] C_MD_DIVU  = 3'd3;
  localparam logic [2:0] C_MD_MTHI  = 3'd4;
  localparam logic [2:0] C_MD_MTLO  = 3'd5;

  localparam int C_MUL_CYCLES_DEF = 5;
  localparam int C_DIV_CYCLES_DEF = 10;

  typedef enum logic [0:0] {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == C_MD_MULT) || (op == C_MD_MULTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_core.sv
// ------------------------------------------------------------------
// md_core : multi-cycle mult/div engine owning the HI/LO registers
// Divider present only when ALU_MD_DIV_EN is defined.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module md_core
  import alu_md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = C_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = C_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  md_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [2:0]         r_op;
  logic               w_long_op, w_accept, w_done, w_mthi, w_mtlo;
  logic [CNT_W-1:0]   w_load;
  logic [WIDTH-1:0]   w_hi_res, w_lo_res;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u;

  always_comb begin
    w_long_op = is_mul(i_op);
    w_load    = MUL_LOAD;
`ifdef ALU_MD_DIV_EN
    if ((i_op == C_MD_DIV) || (i_op == C_MD_DIVU)) begin
      w_long_op = 1'b1;
      w_load    = CNT_W'(DIV_CYCLES - 1);
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_start && w_long_op) begin
          w_accept    = 1'b1;
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (r_cnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  assign w_mthi = (r_state == MD_IDLE) && i_start && (i_op == C_MD_MTHI);
  assign w_mtlo = (r_state == MD_IDLE) && i_start && (i_op == C_MD_MTLO);

  // Sign-extending to 2*WIDTH makes the unsigned product equal the signed one mod 2^(2W).
  assign w_prod_s = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod_u = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

`ifdef ALU_MD_DIV_EN
  logic             w_sdiv, w_neg_a, w_neg_b;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_uq, w_ur, w_q, w_r;

  // Signed divide on magnitudes; MIN / -1 falls out as quotient MIN, remainder 0.
  assign w_sdiv  = (r_op == C_MD_DIV);
  assign w_neg_a = w_sdiv & r_a[WIDTH-1];
  assign w_neg_b = w_sdiv & r_b[WIDTH-1];
  assign w_mag_a = w_neg_a ? -r_a : r_a;
  assign w_mag_b = w_neg_b ? -r_b : r_b;
  assign w_uq    = w_mag_a / w_mag_b;
  assign w_ur    = w_mag_a % w_mag_b;
  assign w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_r     = w_neg_a ? -w_ur : w_ur;
`endif

  always_comb begin
    w_hi_res = r_hi;
    w_lo_res = r_lo;
    case (r_op)
      C_MD_MULT:  {w_hi_res, w_lo_res} = w_prod_s;
      C_MD_MULTU: {w_hi_res, w_lo_res} = w_prod_u;
`ifdef ALU_MD_DIV_EN
      C_MD_DIV, C_MD_DIVU: begin
        if (r_b != '0) begin
          w_hi_res = w_r;
          w_lo_res = w_q;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a   <= i_a;
        r_b   <= i_b;
        r_op  <= i_op;
        r_cnt <= w_load;
      end else if ((r_state == MD_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_hi_res;
      r_lo <= w_lo_res;
    end else if (w_mthi) begin
      r_hi <= i_a;
    end else if (w_mtlo) begin
      r_lo <= i_a;
    end
  end

  assign o_busy = (r_state == MD_BUSY);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

`default_nettype wire

// File: rtl/alu_md.sv
// ------------------------------------------------------------------
// alu_md : combinational MIPS-style ALU beside a mult/div HI/LO engine
// Divider enabled by defining ALU_MD_DIV_EN.  Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module alu_md
  import alu_md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = C_MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = C_DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0]  w_sh;
  logic [WIDTH-1:0] w_sum, w_diff;

  assign w_sh   = B[SH_W-1:0];
  assign w_sum  = A + B;
  assign w_diff = A - B;

  always_comb begin
    Result   = '0;
    Overflow = 1'b0;
    case (ALUOp)
      C_ALU_AND:  Result = A & B;
      C_ALU_OR:   Result = A | B;
      C_ALU_ADD: begin
        Result   = w_sum;
        Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      C_ALU_SUB: begin
        Result   = w_diff;
        Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      C_ALU_XOR:  Result = A ^ B;
      C_ALU_NOR:  Result = ~(A | B);
      C_ALU_SLT:  Result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      C_ALU_SLTU: Result = {{(WIDTH-1){1'b0}}, (A < B)};
      C_ALU_SLL:  Result = A << w_sh;
      C_ALU_SRL:  Result = A >> w_sh;
      C_ALU_SRA:  Result = $signed(A) >>> w_sh;
      C_ALU_LUI:  Result = B << (WIDTH / 2);
      default:    Result = '0;
    endcase
  end

  assign Zero = (A == B);

  md_core #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_core (
    .clk     (clk),
    .reset   (reset),
    .i_start (start),
    .i_op    (MDOp),
    .i_a     (A),
    .i_b     (B),
    .o_busy  (busy),
    .o_hi    (HI),
    .o_lo    (LO)
  );

endmodule

`default_nettype wire

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits (even, >= 8).
REQ-002 Parameter MUL_CYCLES, default 5, busy cycles per multiply (>= 1).
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles per divide (>= 1).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 A  in  WIDTH  operand A / rs.
REQ-007 B  in  WIDTH  operand B / rt.
REQ-008 ALUOp  in  4  combinational op select.
REQ-009 MDOp  in  3  mult/div op select, qualified by start.
REQ-010 start  in  1  request to launch MDOp this cycle.
REQ-011 Result  out  WIDTH  combinational ALU result.
REQ-012 Zero  out  1  1 iff A == B.
REQ-013 Overflow  out  1  signed overflow of ADD/SUB; 0 for all other ops.
REQ-014 busy  out  1  mult/div engine occupied.
REQ-015 HI  out  WIDTH  HI register; LO  out  WIDTH  LO register.

Function
REQ-016 ALUOp: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 SLT (signed, result 0/1), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI (B << WIDTH/2); 12-15 give Result = 0.
REQ-017 Shifts: A shifted by B[$clog2(WIDTH)-1:0]; upper B bits ignored.
REQ-018 ADD/SUB wrap modulo 2^WIDTH; Overflow flags signed overflow only.
REQ-019 Result, Zero, Overflow purely combinational, independent of busy.
REQ-020 MDOp: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6-7 no effect.
REQ-021 start with MDOp 0-3 accepted in cycle t only if busy = 0; operands A, B and op latched at edge ending t.
REQ-022 Accepted mult: busy = 1 for cycles t+1 .. t+MUL_CYCLES; {HI,LO} = full 2*WIDTH product, visible from t+MUL_CYCLES+1; busy = 0 in that cycle.
REQ-023 Accepted div: same timing with DIV_CYCLES; LO = quotient truncated toward zero, HI = remainder with dividend sign (unsigned for DIVU).
REQ-024 Divide by zero: busy timing unchanged; HI and LO retain prior values.
REQ-025 DIV of most-negative by -1: LO = most-negative, HI = 0.
REQ-026 MTHI/MTLO with start = 1 and busy = 0: HI (resp. LO) = A at the edge ending t; no busy.
REQ-027 Any start while busy = 1 is ignored; in-flight operation and HI/LO unaffected.
REQ-028 HI/LO hold old values throughout busy; only the final edge writes them.
REQ-029 A new start may be accepted in the first cycle busy = 0 (back-to-back ops).

Reset
REQ-030 reset asserted: busy = 0, HI = 0, LO = 0, cycle counter = 0, latched operands cleared, immediately and asynchronously.
REQ-031 Reset mid-operation aborts it; no HI/LO write occurs after reset release.
REQ-032 First start is accepted in the first cycle after reset deasserts.

Configuration
REQ-033 Macro ALU_MD_DIV_EN: defined -> DIV/DIVU as specified.
REQ-034 Undefined -> MDOp 2-3 act as no-ops (busy stays 0, HI/LO unchanged); no divider logic synthesised.

Structure
REQ-035 Package alu_md_pkg holds ALUOp and MDOp encodings as named constants and default cycle-count constants.
REQ-036 Sub-module md_core holds operand latches, cycle counter, product/quotient computation and HI/LO; alu_md instantiates it beside the combinational ALU.

Verification
REQ-037 ADD A=0x7FFFFFFF B=1 -> Result=0x80000000, Overflow=1; SUB A=5 B=5 -> Result=0, Zero=1.
REQ-038 SRA A=4 B=0x80000000 wait operand order: B=4? Bench uses SRA with A=0x80000000, B=4 -> Result=0xF8000000; SLT A=0xFFFFFFFF B=1 -> 1, SLTU -> 0.
REQ-039 MULT A=0xFFFFFFFF B=2 start at t -> busy 1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; MULTU same operands -> HI=1, LO=0xFFFFFFFE.
REQ-040 DIV A=-7 B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV B=0 -> HI/LO unchanged.
REQ-041 MTLO A=0x1234 during busy -> ignored; same after busy falls -> LO=0x1234 next cycle.
REQ-042 reset pulsed at busy cycle 3 of a MULT -> busy=0, HI=LO=0, no later write; new MULT accepted next cycle.
